// File: rtl/prince_fwd_iter.sv
// Iterative forward half of PRINCE: one round (S-layer, M-layer, RC_i ^ k1) per clock.
// Nibble i of the 64-bit state is bits [4i+3:4i]; M' column c is bits [16c+15:16c].

module sbox (
   input  logic [3:0] din,
   output logic [3:0] dout
);
   // PRINCE forward S-box lookup
   always_comb begin
      case (din)
         4'h0: dout = 4'hb;
         4'h1: dout = 4'hf;
         4'h2: dout = 4'h3;
         4'h3: dout = 4'h2;
         4'h4: dout = 4'ha;
         4'h5: dout = 4'hc;
         4'h6: dout = 4'h9;
         4'h7: dout = 4'h1;
         4'h8: dout = 4'h6;
         4'h9: dout = 4'h7;
         4'ha: dout = 4'h8;
         4'hb: dout = 4'h0;
         4'hc: dout = 4'he;
         4'hd: dout = 4'h5;
         4'he: dout = 4'hd;
         4'hf: dout = 4'h4;
         default: dout = 4'h0;
      endcase
   end
endmodule

module mat (
   input  logic [63:0] din,
   output logic [63:0] dout
);
   logic [63:0] mp_s;

   // Mhat block (j,k) is M_((j+k+off) mod 4); M_m clears bit m of a nibble
   function automatic logic [15:0] mhat(input logic [15:0] x, input logic [1:0] off);
      logic [15:0] y;
      logic [1:0]  m;
      y = 16'h0000;
      for (int j = 0; j < 4; j++) begin
         for (int k = 0; k < 4; k++) begin
            m = 2'(j + k) + off;
            y[4*j +: 4] = y[4*j +: 4] ^ (x[4*k +: 4] & ~(4'b0001 << m));
         end
      end
      return y;
   endfunction

   // M' = diag(Mhat0, Mhat1, Mhat1, Mhat0), then ShiftRows (out nibble i = in nibble 5i mod 16)
   always_comb begin
      dout = 64'h0;
      mp_s = {mhat(din[63:48], 2'd0), mhat(din[47:32], 2'd1),
              mhat(din[31:16], 2'd1), mhat(din[15:0],  2'd0)};
      for (int i = 0; i < 16; i++) begin
         dout[4*i +: 4] = mp_s[4*((5*i) % 16) +: 4];
      end
   end
endmodule

module prince_fwd_iter #(
   parameter int ROUNDS = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_data,
   input  logic [63:0] in_key,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} fsm_t;

   fsm_t        fsm_r, fsm_nx;
   logic [2:0]  cnt_r;
   logic [63:0] state_r, key_r, sub_s, mix_s;

   function automatic logic [63:0] rc(input logic [2:0] idx);
      case (idx)
         3'd1:    return 64'h13198a2e03707344;
         3'd2:    return 64'ha4093822299f31d0;
         3'd3:    return 64'h082efa98ec4e6c89;
         3'd4:    return 64'h452821e638d01377;
         3'd5:    return 64'hbe5466cf34e90c6c;
         default: return 64'h0000000000000000;
      endcase
   endfunction

   for (genvar g = 0; g < 16; g++) begin : g_sbox
      sbox u_sbox (.din(state_r[4*g +: 4]), .dout(sub_s[4*g +: 4]));
   end

   mat u_mat (.din(sub_s), .dout(mix_s));

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_r <= IDLE;
      end else begin
         fsm_r <= fsm_nx;
      end
   end

   // FSM next-state logic
   always_comb begin
      fsm_nx = fsm_r;
      case (fsm_r)
         IDLE: begin
            if (in_valid) fsm_nx = RUN;
            else          fsm_nx = IDLE;
         end
         RUN: begin
            if (cnt_r == 3'(ROUNDS)) fsm_nx = DONE;
            else                     fsm_nx = RUN;
         end
         DONE: begin
            if (out_ready) fsm_nx = IDLE;
            else           fsm_nx = DONE;
         end
         default: fsm_nx = IDLE;
      endcase
   end

   // Round datapath: whitening load on accept, one round per RUN cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= 64'h0;
         key_r   <= 64'h0;
         cnt_r   <= 3'd0;
      end else begin
         case (fsm_r)
            IDLE: begin
               if (in_valid) begin
                  state_r <= in_data ^ in_key ^ rc(3'd0);
                  key_r   <= in_key;
                  cnt_r   <= 3'd1;
               end
            end
            RUN: begin
               state_r <= mix_s ^ rc(cnt_r) ^ key_r;
               cnt_r   <= cnt_r + 3'd1;
            end
            default: begin
               state_r <= state_r;
            end
         endcase
      end
   end

   // Outputs decoded from registered state only
   always_comb begin
      in_ready  = (fsm_r == IDLE);
      out_valid = (fsm_r == DONE);
      if (fsm_r == DONE) out_data = state_r;
      else               out_data = 64'h0;
   end
endmodule

// File: tb/tb_prince_fwd_iter.sv
// Randomized self-checking bench for prince_fwd_iter against a nibble/bit-level
// reference model of the forward PRINCE rounds and its inverse.

module tb_prince_fwd_iter;
   localparam int ROUNDS = 5;

   localparam logic [63:0] RCT [0:5] = '{
      64'h0000000000000000, 64'h13198a2e03707344, 64'ha4093822299f31d0,
      64'h082efa98ec4e6c89, 64'h452821e638d01377, 64'hbe5466cf34e90c6c};
   localparam logic [3:0] SB  [0:15] = '{4'hb, 4'hf, 4'h3, 4'h2, 4'ha, 4'hc, 4'h9, 4'h1,
                                         4'h6, 4'h7, 4'h8, 4'h0, 4'he, 4'h5, 4'hd, 4'h4};
   localparam logic [3:0] SBI [0:15] = '{4'hb, 4'h7, 4'h3, 4'h2, 4'hf, 4'hd, 4'h8, 4'h9,
                                         4'ha, 4'h6, 4'h4, 4'h0, 4'h5, 4'he, 4'hc, 4'h1};
   localparam int SRT [0:15] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready;
   logic [63:0] in_data, in_key, out_data;
   int          total = 0;
   int          bad = 0;

   prince_fwd_iter #(.ROUNDS(ROUNDS)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_key(in_key), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data));

   always #5 clk = ~clk;

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   function automatic logic [63:0] sub_layer(input logic [63:0] x, input bit inv);
      logic [63:0] y;
      for (int i = 0; i < 16; i++) y[4*i +: 4] = inv ? SBI[x[4*i +: 4]] : SB[x[4*i +: 4]];
      return y;
   endfunction

   // bit b of output nibble j in column c keeps input bit b of nibble k unless b == (j+k+off) mod 4
   function automatic logic [63:0] mprime(input logic [63:0] x);
      logic [63:0] y;
      logic v;
      int off;
      y = 64'h0;
      for (int c = 0; c < 4; c++) begin
         off = (c == 1 || c == 2) ? 1 : 0;
         for (int j = 0; j < 4; j++) begin
            for (int b = 0; b < 4; b++) begin
               v = 1'b0;
               for (int k = 0; k < 4; k++) if (((j + k + off) % 4) != b) v ^= x[16*c + 4*k + b];
               y[16*c + 4*j + b] = v;
            end
         end
      end
      return y;
   endfunction

   function automatic logic [63:0] shift_rows(input logic [63:0] x, input bit inv);
      logic [63:0] y;
      for (int i = 0; i < 16; i++) begin
         if (inv) y[4*SRT[i] +: 4] = x[4*i +: 4];
         else     y[4*i +: 4] = x[4*SRT[i] +: 4];
      end
      return y;
   endfunction

   function automatic logic [63:0] fwd_model(input logic [63:0] d, input logic [63:0] k);
      logic [63:0] s;
      s = d ^ k ^ RCT[0];
      for (int r = 1; r <= ROUNDS; r++) s = shift_rows(mprime(sub_layer(s, 1'b0)), 1'b0) ^ RCT[r] ^ k;
      return s;
   endfunction

   function automatic logic [63:0] inv_model(input logic [63:0] c, input logic [63:0] k);
      logic [63:0] s;
      s = c;
      for (int r = ROUNDS; r >= 1; r--) begin
         s = s ^ RCT[r] ^ k;
         s = sub_layer(mprime(shift_rows(s, 1'b1)), 1'b1);
      end
      return s ^ k ^ RCT[0];
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Starts at a negedge with the DUT idle; ends at a negedge with the DUT idle again.
   task automatic do_block(input logic [63:0] d, input logic [63:0] k, input int hold,
                           output logic [63:0] res);
      int n;
      logic [63:0] exp;
      exp = fwd_model(d, k);
      check("idle_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b1; in_data = d; in_key = k; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0; in_data = rnd64(); in_key = rnd64();
      n = 1;
      while (out_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("latency", 64'(n), 64'(ROUNDS + 1));
      check("result", out_data, exp);
      res = out_data;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", 64'(out_valid), 64'd1);
         check("hold_data", out_data, exp);
         check("hold_busy", 64'(in_ready), 64'd0);
         in_valid = (i == 3) ? 1'b1 : 1'b0;
         in_data = rnd64(); in_key = rnd64();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("release_valid", 64'(out_valid), 64'd0);
      check("release_ready", 64'(in_ready), 64'd1);
      check("release_data", out_data, 64'd0);
   endtask

   initial begin
      logic [63:0] res, d, k;
      logic [63:0] q[$];
      int cyc, last_acc, accepts, results, busy_rdy;

      // reset with random inputs
      rst = 1'b1; in_valid = 1'($urandom); in_data = rnd64(); in_key = rnd64();
      out_ready = 1'($urandom);
      repeat (2) @(negedge clk);
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      check("rst_ready", 64'(in_ready), 64'd1);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_data", out_data, 64'd0);

      do_block(64'h0, 64'h0, 0, res);

      d = 64'h0123456789abcdef;
      do_block(d, 64'h0, 0, res);
      check("roundtrip_k0", inv_model(res, 64'h0), d);
      do_block(d, 64'hfedcba9876543210, 0, res);
      check("roundtrip_k1", inv_model(res, 64'hfedcba9876543210), d);

      do_block(rnd64(), rnd64(), 10, res);

      // reset during round 3 discards the block
      in_valid = 1'b1; in_data = rnd64(); in_key = rnd64();
      repeat (3) begin
         @(negedge clk);
         in_valid = 1'b0;
         check("midrun_novalid", 64'(out_valid), 64'd0);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrun_rst_valid", 64'(out_valid), 64'd0);
      d = rnd64(); k = rnd64();
      do_block(d, k, 0, res);
      check("midrun_roundtrip", inv_model(res, k), d);

      for (int v = 0; v < 1000; v++) begin
         d = rnd64(); k = rnd64();
         do_block(d, k, 0, res);
         if (v < 20) check("rand_roundtrip", inv_model(res, k), d);
      end

      // back-to-back with in_valid and out_ready held high
      cyc = 0; last_acc = -1; accepts = 0; results = 0; busy_rdy = 0;
      in_valid = 1'b1; out_ready = 1'b1;
      while (results < 4 && cyc < 60) begin
         if (out_valid) begin
            if (q.size() > 0) check("b2b_data", out_data, q.pop_front());
            else check("b2b_extra", 64'(out_valid), 64'd0);
            results++;
            if (in_ready) busy_rdy++;
         end
         in_data = rnd64(); in_key = rnd64();
         if (in_ready) begin
            if (accepts < 4) begin
               q.push_back(fwd_model(in_data, in_key));
               if (last_acc >= 0) check("b2b_gap", 64'(cyc - last_acc), 64'(ROUNDS + 2));
               last_acc = cyc;
               accepts++;
            end else begin
               in_valid = 1'b0;
            end
         end
         @(negedge clk);
         cyc++;
      end
      check("b2b_results", 64'(results), 64'd4);
      check("b2b_busy_ready", 64'(busy_rdy), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
